// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller around a WIDTH-bit up-counter.
// It launches, pauses, aborts and detects a latched terminal value. In one-shot
// mode it stops at the terminal value. In auto-reload mode it wraps to zero and
// counts the reload events in a saturating counter.
//
// Handshake: start, stop and pause are level inputs that are sampled at every
// rising edge. start acts only in IDLE or DONE. stop acts in every state and
// takes priority over everything except rst. pause acts only in RUN or PAUSE.
// done is a single-cycle registered pulse. It has no acknowledge.
module count_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int RCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode_reload,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [RCW-1:0]   reload_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [RCW-1:0] RC_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic [RCW-1:0]   reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, paused_q;
  logic             at_term;

  // The counter has reached the terminal value latched at launch.
  assign at_term = (cnt_q == term_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. The priority is stop, then terminal, then pause.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) state_d = (term_val == '0) ? S_DONE : S_RUN;
          else       state_d = S_IDLE;
        end
        S_RUN: begin
          if (at_term)    state_d = mode_q ? S_RUN : S_DONE;
          else if (pause) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (!pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values: the counter, the latched launch settings, the reload count and done.
  always_comb begin
    cnt_d    = cnt_q;
    term_d   = term_q;
    mode_d   = mode_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (stop) begin
      // An abort from an active count clears the counter. A stop while idle leaves it as it is.
      if (state_q == S_RUN || state_q == S_PAUSE) cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            term_d   = term_val;
            mode_d   = mode_reload;
            cnt_d    = '0;
            reload_d = '0;
            done_d   = (term_val == '0);
          end
        end
        S_RUN: begin
          if (at_term) begin
            done_d = 1'b1;
            if (mode_q) begin
              cnt_d = '0;
              if (reload_q != RC_MAX) reload_d = reload_q + RCW'(1);
            end
          end else if (!pause) begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and status registers. Status is decoded from the next state so it stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      term_q   <= '0;
      mode_q   <= 1'b0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      term_q   <= term_d;
      mode_q   <= mode_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= (state_d == S_RUN) || (state_d == S_PAUSE);
      paused_q <= (state_d == S_PAUSE);
    end
  end

  assign cnt_out    = cnt_q;
  assign busy       = busy_q;
  assign paused     = paused_q;
  assign done       = done_q;
  assign reload_cnt = reload_q;
  assign state      = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Testbench for count_seq_ctrl. It checks a vector table, hand-written corner sequences,
// and random traffic against a behavioural model.
module tb_count_seq_ctrl;

  logic       clk;
  logic       rst, start, stop, pause, mode_reload;
  logic [3:0] term_val;
  logic [3:0] cnt_out;
  logic       busy, paused, done;
  logic [7:0] reload_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry layout: {state[1:0], busy, paused, done, reload[7:0], cnt[3:0]}.
  logic [16:0] exp_q[$];

  // Behavioural model, described in terms of activity flags and plain integers.
  bit m_active, m_hold, m_fin, m_done, m_auto;
  int m_cnt, m_term, m_rel;

  count_seq_ctrl #(.WIDTH(4), .RCW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode_reload(mode_reload), .term_val(term_val), .cnt_out(cnt_out),
    .busy(busy), .paused(paused), .done(done), .reload_cnt(reload_cnt),
    .state(state)
  );

  // Clock and initial input values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic st, input logic sp,
                            input logic p, input logic m, input logic [3:0] tv);
    int sv;
    if (r) begin
      m_active = 0; m_hold = 0; m_fin = 0; m_done = 0; m_auto = 0;
      m_cnt = 0; m_term = 0; m_rel = 0;
    end else if (sp) begin
      if (m_active) m_cnt = 0;
      m_active = 0; m_hold = 0; m_fin = 0; m_done = 0;
    end else if (!m_active) begin
      m_done = 0;
      m_fin  = 0;
      if (st) begin
        m_term = int'(tv); m_auto = m; m_cnt = 0; m_rel = 0;
        if (m_term == 0) begin m_fin = 1; m_done = 1; end
        else m_active = 1;
      end
    end else if (!m_hold) begin
      if (m_cnt == m_term) begin
        m_done = 1;
        if (m_auto) begin
          m_cnt = 0;
          if (m_rel < 255) m_rel = m_rel + 1;
        end else begin
          m_active = 0; m_fin = 1;
        end
      end else begin
        m_done = 0;
        if (p) m_hold = 1;
        else   m_cnt = m_cnt + 1;
      end
    end else begin
      m_done = 0;
      if (!p) m_hold = 0;
    end
    sv = m_fin ? 3 : (m_hold ? 2 : (m_active ? 1 : 0));
    exp_q.push_back({2'(sv), m_active, m_hold, m_done, 8'(m_rel), 4'(m_cnt)});
  endtask

  // Driver: drive at the falling edge, let the DUT and the model advance at the rising edge,
  // then check 1 time unit later.
  task automatic step(input logic r, input logic st, input logic sp,
                      input logic p, input logic m, input logic [3:0] tv);
    logic [16:0] e;
    @(negedge clk);
    rst = r; start = st; stop = sp; pause = p; mode_reload = m; term_val = tv;
    @(posedge clk);
    model_step(r, st, sp, p, m, tv);
    #1;
    e = exp_q.pop_front();
    chk("sb_state",  int'(state),      int'(e[16:15]));
    chk("sb_busy",   int'(busy),       int'(e[14]));
    chk("sb_paused", int'(paused),     int'(e[13]));
    chk("sb_done",   int'(done),       int'(e[12]));
    chk("sb_reload", int'(reload_cnt), int'(e[11:4]));
    chk("sb_cnt",    int'(cnt_out),    int'(e[3:0]));
  endtask

  typedef struct {
    int rst, start, stop, pause, mode, term;
    int e_cnt, e_busy, e_paused, e_done, e_rel, e_state;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode_reload = 1'b0; term_val = 4'd0;

    // Reset for two edges while the other inputs are random.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    chk("rst_state", int'(state), 0);
    chk("rst_cnt", int'(cnt_out), 0);
    chk("rst_flags", int'({busy, paused, done}), 0);
    chk("rst_reload", int'(reload_cnt), 0);

    // Vector table: a one-shot run, a zero terminal value, a relaunch from DONE, and stop.
    //          rst st sp p  m  term  cnt busy psd done rel state
    vecs[0]  = '{0, 1, 0, 0, 0, 3,    0,  1,   0,  0,   0,  1};
    vecs[1]  = '{0, 0, 0, 0, 1, 9,    1,  1,   0,  0,   0,  1};
    vecs[2]  = '{0, 0, 0, 0, 0, 3,    2,  1,   0,  0,   0,  1};
    vecs[3]  = '{0, 1, 0, 0, 0, 3,    3,  1,   0,  0,   0,  1};
    vecs[4]  = '{0, 0, 0, 0, 0, 3,    3,  0,   0,  1,   0,  3};
    vecs[5]  = '{0, 0, 0, 0, 0, 3,    3,  0,   0,  0,   0,  0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0,    0,  0,   0,  1,   0,  3};
    vecs[7]  = '{0, 0, 0, 0, 0, 0,    0,  0,   0,  0,   0,  0};
    vecs[8]  = '{0, 1, 0, 0, 0, 1,    0,  1,   0,  0,   0,  1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1,    1,  1,   0,  0,   0,  1};
    vecs[10] = '{0, 0, 0, 0, 0, 1,    1,  0,   0,  1,   0,  3};
    vecs[11] = '{0, 1, 0, 0, 0, 2,    0,  1,   0,  0,   0,  1};
    vecs[12] = '{0, 0, 0, 0, 0, 2,    1,  1,   0,  0,   0,  1};
    vecs[13] = '{0, 0, 1, 0, 0, 2,    0,  0,   0,  0,   0,  0};
    vecs[14] = '{0, 0, 1, 0, 0, 2,    0,  0,   0,  0,   0,  0};
    foreach (vecs[i]) begin
      step(vecs[i].rst != 0, vecs[i].start != 0, vecs[i].stop != 0,
           vecs[i].pause != 0, vecs[i].mode != 0, 4'(vecs[i].term));
      chk($sformatf("vec%0d_cnt", i),    int'(cnt_out),    vecs[i].e_cnt);
      chk($sformatf("vec%0d_busy", i),   int'(busy),       vecs[i].e_busy);
      chk($sformatf("vec%0d_paused", i), int'(paused),     vecs[i].e_paused);
      chk($sformatf("vec%0d_done", i),   int'(done),       vecs[i].e_done);
      chk($sformatf("vec%0d_reload", i), int'(reload_cnt), vecs[i].e_rel);
      chk($sformatf("vec%0d_state", i),  int'(state),      vecs[i].e_state);
    end

    // Pause at count 2 for three edges on a terminal value of 5, then resume.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    chk("pz_pre_cnt", int'(cnt_out), 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      chk("pz_paused", int'(paused), 1);
      chk("pz_hold_cnt", int'(cnt_out), 2);
      chk("pz_state", int'(state), 2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    chk("pz_resume_state", int'(state), 1);
    chk("pz_resume_cnt", int'(cnt_out), 2);
    for (int c = 3; c <= 5; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
      chk("pz_run_cnt", int'(cnt_out), c);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
    chk("pz_done", int'(done), 1);
    chk("pz_done_state", int'(state), 3);
    chk("pz_done_cnt", int'(cnt_out), 5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);

    // Auto-reload with a terminal value of 15 for 50 edges, then stop.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      if (done) dones++;
    end
    chk("ar_dones", dones, 3);
    chk("ar_reload", int'(reload_cnt), 3);
    chk("ar_state", int'(state), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    chk("ar_stop_state", int'(state), 0);
    chk("ar_stop_cnt", int'(cnt_out), 0);
    chk("ar_stop_busy", int'(busy), 0);
    chk("ar_stop_done", int'(done), 0);

    // Reset in the middle of a run at count 7 of a terminal value of 12.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd12);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
    chk("ab_cnt7", int'(cnt_out), 7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12);
    chk("ab_rst_state", int'(state), 0);
    chk("ab_rst_cnt", int'(cnt_out), 0);
    chk("ab_rst_busy", int'(busy), 0);
    // start and stop on the same edge: stop wins.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
    chk("ss_state", int'(state), 0);
    chk("ss_busy", int'(busy), 0);
    chk("ss_done", int'(done), 0);

    // Random traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] tv;
      tv = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, tv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
